path_sequencer: RTL

Mission-level controller that sits in front of `path_planner` and sequences it. Accepts a queue of goal nodes and issues one plan request per goal, from the bot's current node to that goal. Unpacks the returned 10-slot path and streams the nodes one at a time to the motion controller over a valid/ready handshake. Tracks the bot's current node as each hop is acknowledged.

---
 rtl/path_seq_pkg.sv | 20 ++
 rtl/goal_fifo.sv | 51 +++++
 rtl/path_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/path_seq_pkg.sv
// Shared constants and state encoding for path_sequencer.
// NODE_W / PATH_LEN / FILL_NODE match the path_planner result format.
package path_seq_pkg;

  localparam int unsigned NODE_W       = 5;
  localparam int unsigned PATH_LEN     = 10;
  localparam int unsigned FILL_NODE    = 27;
  localparam int unsigned START_NODE   = 0;
  localparam int unsigned QDEPTH       = 4;
  localparam int unsigned PLAN_TIMEOUT = 4095;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_PLAN,
    S_LOAD,
    S_STREAM
  } state_t;

endpackage

// File: rtl/goal_fifo.sv
// goal_fifo: synchronous show-ahead FIFO with occupancy count and async reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module goal_fifo #(
  parameter  int unsigned WIDTH = 5,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/path_sequencer.sv
// path_sequencer: pops goals, requests a plan from path_planner for each,
// then streams the returned hops to the motion controller.
// Optional feature macro: PATH_SEQ_RETURN_HOME_EN (plan back to START_NODE
// whenever the goal queue drains away from home).
module path_sequencer #(
  parameter int unsigned NODE_W       = path_seq_pkg::NODE_W,
  parameter int unsigned PATH_LEN     = path_seq_pkg::PATH_LEN,
  parameter int unsigned FILL_NODE    = path_seq_pkg::FILL_NODE,
  parameter int unsigned START_NODE   = path_seq_pkg::START_NODE,
  parameter int unsigned QDEPTH       = path_seq_pkg::QDEPTH,
  parameter int unsigned PLAN_TIMEOUT = path_seq_pkg::PLAN_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       goal_valid,
  input  logic [NODE_W-1:0]          goal_node,
  output logic                       goal_ready,
  output logic                       pp_start,
  output logic [NODE_W-1:0]          pp_s_node,
  output logic [NODE_W-1:0]          pp_e_node,
  input  logic                       pp_done,
  input  logic [NODE_W*PATH_LEN-1:0] pp_final_path,
  output logic                       step_valid,
  output logic [NODE_W-1:0]          step_node,
  input  logic                       step_ready,
  output logic [NODE_W-1:0]          cur_node,
  output logic                       busy,
  output logic                       error
);

  import path_seq_pkg::*;

  localparam int unsigned PTR_W  = $clog2(PATH_LEN);
  localparam int unsigned TMO_W  = $clog2(PLAN_TIMEOUT + 1);
  localparam int unsigned CNT_W  = $clog2(QDEPTH + 1);
  localparam int unsigned PATH_W = NODE_W * PATH_LEN;

  localparam logic [NODE_W-1:0] FILL     = NODE_W'(FILL_NODE);
  localparam logic [NODE_W-1:0] HOME     = NODE_W'(START_NODE);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(PLAN_TIMEOUT - 1);

  state_t            state;
  logic [PATH_W-1:0] path_q;
  logic [PTR_W-1:0]  ptr;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [NODE_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              home_req;

  logic [PTR_W-1:0]  top_idx;
  logic [NODE_W-1:0] top_node;
  logic [NODE_W-1:0] first_hop;
  logic [NODE_W-1:0] next_hop;

  goal_fifo #(
    .WIDTH (NODE_W),
    .DEPTH (QDEPTH)
  ) u_goal_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (goal_valid && goal_ready),
    .data_in (goal_node),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign goal_ready = !fifo_full;
  // Every non-empty IDLE cycle consumes the head, including goals already at cur_node.
  assign fifo_pop   = (state == S_IDLE) && !fifo_empty;

`ifdef PATH_SEQ_RETURN_HOME_EN
  assign home_req = (fifo_count == '0) && (cur_node != HOME);
`else
  assign home_req = 1'b0;
`endif

  // Highest non-fill slot of the incoming path is the route source.
  always_comb begin
    top_idx = '0;
    for (int unsigned k = 0; k < PATH_LEN; k++) begin
      if (pp_final_path[NODE_W*k +: NODE_W] != FILL) top_idx = PTR_W'(k);
    end
  end

  // Slot lookups: source, first hop below it, and the hop after the current one.
  always_comb begin
    top_node  = pp_final_path[NODE_W*32'(top_idx) +: NODE_W];
    first_hop = '0;
    next_hop  = '0;
    if (top_idx != '0) first_hop = pp_final_path[NODE_W*32'(top_idx - PTR_W'(1)) +: NODE_W];
    if (ptr != '0)     next_hop  = path_q[NODE_W*32'(ptr - PTR_W'(1)) +: NODE_W];
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pp_start   <= 1'b0;
      pp_s_node  <= '0;
      pp_e_node  <= '0;
      step_valid <= 1'b0;
      step_node  <= '0;
      cur_node   <= HOME;
      busy       <= 1'b0;
      error      <= 1'b0;
      path_q     <= '0;
      ptr        <= '0;
      tmo_cnt    <= '0;
    end else begin
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fifo_count != '0) begin
            if (fifo_head != cur_node) begin
              pp_s_node <= cur_node;
              pp_e_node <= fifo_head;
              pp_start  <= 1'b1;
              busy      <= 1'b1;
              tmo_cnt   <= '0;
              state     <= S_REQ;
            end
          end else if (home_req) begin
            pp_s_node <= cur_node;
            pp_e_node <= HOME;
            pp_start  <= 1'b1;
            busy      <= 1'b1;
            tmo_cnt   <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (!pp_done) begin
            pp_start <= 1'b0;
            tmo_cnt  <= '0;
            state    <= S_PLAN;
          end else if (tmo_cnt == TMO_LAST) begin
            pp_start <= 1'b0;
            error    <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_PLAN: begin
          if (pp_done) begin
            state <= S_LOAD;
          end else if (tmo_cnt == TMO_LAST) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_LOAD: begin
          path_q <= pp_final_path;
          if ((top_idx == '0) || (top_node != cur_node)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            ptr        <= top_idx - PTR_W'(1);
            step_node  <= first_hop;
            step_valid <= 1'b1;
            state      <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (step_ready) begin
            cur_node <= step_node;
            if (ptr == '0) begin
              step_valid <= 1'b0;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end else begin
              ptr       <= ptr - PTR_W'(1);
              step_node <= next_hop;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
